m_ldst_unit: RTL and testbench

M_LDST_UNIT -- requirements
Module: m_ldst_unit

---
 rtl/m_ldst_unit.sv | 201 ++++++++++++++++++++
 tb/tb_m_ldst_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ldst_unit.sv
// ---------------------------------------------------------------------------
// m_ldst_unit
// Load/store unit: turns one byte/half/word/dword request into one or two
// NB-aligned bus beats, assembles and extends load data, and returns a
// single-cycle response. Misaligned or illegal-size requests fault without
// touching the bus.
//
// Parameters
//   DATA_W          bus/data width, 32 or 64 (NB = DATA_W/8 byte lanes)
//   ALLOW_UNALIGNED 1: split line-crossing accesses into two beats
//                   0: any access not aligned to its size faults
// Ports
//   clk, reset      clock, synchronous active-high reset
//   req_*           request handshake (valid/ready) and request fields
//   bus_*           memory bus (valid/ready), NB-aligned address, lane enables
//   rsp_*           one-cycle response: load data and fault flag
// ---------------------------------------------------------------------------
module m_ldst_unit #(
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned ALLOW_UNALIGNED = 0
) (
   input  logic                clk,
   input  logic                reset,
   // Request
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [31:0]         req_addr,
   input  logic [1:0]          req_size,
   input  logic                req_signed,
   input  logic [DATA_W-1:0]   req_wdata,
   // Bus
   output logic                bus_valid,
   input  logic                bus_ready,
   output logic                bus_we,
   output logic [31:0]         bus_addr,
   output logic [DATA_W/8-1:0] bus_be,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   // Response
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_exc
);

   localparam int unsigned NB   = DATA_W / 8;
   localparam int unsigned OFFW = $clog2(NB);

   typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

   state_e              r_state, w_state_next;
   logic [31:0]         r_addr;
   logic [1:0]          r_size;
   logic                r_signed;
   logic                r_we;
   logic                r_fault;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_raw;   // load bytes gathered so far, right-justified

   logic                w_accept;
   logic                w_req_misalign;
   logic                w_req_fault;
   logic [OFFW-1:0]     w_off;
   logic [NB-1:0]       w_nmask;
   logic [2*NB-1:0]     w_be_full;
   logic [2*DATA_W-1:0] w_wd_full;
   logic                w_split;
   logic [31:0]         w_base;
   logic [OFFW+3:0]     w_hi_sh;
   int unsigned         w_nbits;
   int unsigned         w_ext_sh;
   logic [DATA_W-1:0]   w_tmp;
   logic signed [DATA_W-1:0] w_tmp_s;
   logic [DATA_W-1:0]   w_ext;

   assign w_accept = req_valid && (r_state == StIdle);

   // Alignment of the incoming request relative to its own size.
   always_comb begin
      w_req_misalign = 1'b0;
      unique case (req_size)
         2'd0: w_req_misalign = 1'b0;
         2'd1: w_req_misalign = req_addr[0];
         2'd2: w_req_misalign = |req_addr[1:0];
         2'd3: w_req_misalign = |req_addr[2:0];
         default: w_req_misalign = 1'b0;
      endcase
   end

   assign w_req_fault = ((req_size == 2'd3) && (DATA_W == 32)) ||
                        ((ALLOW_UNALIGNED == 0) && w_req_misalign);

   // Lane layout of the latched access across two consecutive bus words:
   // low half of each *_full vector is BEAT0, high half is BEAT1.
   assign w_off = r_addr[OFFW-1:0];

   always_comb begin
      w_nmask = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         w_nmask[i] = (i < (32'd1 << r_size));
      end
   end

   assign w_be_full = {{NB{1'b0}}, w_nmask} << w_off;
   assign w_wd_full = {{DATA_W{1'b0}}, r_wdata} << {w_off, 3'b000};
   assign w_split   = |w_be_full[2*NB-1:NB];
   assign w_base    = {r_addr[31:OFFW], {OFFW{1'b0}}};
   // BEAT1 lanes land above the NB-off bytes already gathered in BEAT0.
   assign w_hi_sh   = (OFFW+4)'(NB * 8) - {1'b0, w_off, 3'b000};

   // Zero/sign extension of the gathered n*8-bit value.
   always_comb begin
      w_nbits  = 32'd8 << r_size;
      w_ext_sh = (w_nbits >= DATA_W) ? 32'd0 : (DATA_W - w_nbits);
      w_tmp    = r_raw << w_ext_sh;
      w_tmp_s  = w_tmp;
      if (r_signed) begin
         w_ext = w_tmp_s >>> w_ext_sh;
      end else begin
         w_ext = w_tmp >> w_ext_sh;
      end
   end

   // Next-state and outputs.
   always_comb begin
      w_state_next = r_state;
      req_ready    = 1'b0;
      bus_valid    = 1'b0;
      bus_we       = 1'b0;
      bus_addr     = '0;
      bus_be       = '0;
      bus_wdata    = '0;
      rsp_valid    = 1'b0;
      rsp_rdata    = '0;
      rsp_exc      = 1'b0;
      unique case (r_state)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_next = w_req_fault ? StResp : StBeat0;
            end
         end
         StBeat0: begin
            bus_valid = 1'b1;
            bus_we    = r_we;
            bus_addr  = w_base;
            bus_be    = w_be_full[NB-1:0];
            bus_wdata = w_wd_full[DATA_W-1:0];
            if (bus_ready) begin
               w_state_next = w_split ? StBeat1 : StResp;
            end
         end
         StBeat1: begin
            bus_valid = 1'b1;
            bus_we    = r_we;
            bus_addr  = w_base + 32'(NB);
            bus_be    = w_be_full[2*NB-1:NB];
            bus_wdata = w_wd_full[2*DATA_W-1:DATA_W];
            if (bus_ready) begin
               w_state_next = StResp;
            end
         end
         StResp: begin
            rsp_valid    = 1'b1;
            rsp_exc      = r_fault;
            rsp_rdata    = (r_we || r_fault) ? '0 : w_ext;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_addr   <= '0;
         r_size   <= '0;
         r_signed <= 1'b0;
         r_we     <= 1'b0;
         r_fault  <= 1'b0;
         r_wdata  <= '0;
         r_raw    <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_we     <= req_we;
            r_fault  <= w_req_fault;
            r_wdata  <= req_wdata;
            r_raw    <= '0;
         end else if ((r_state == StBeat0) && bus_ready) begin
            r_raw <= bus_rdata >> {w_off, 3'b000};
         end else if ((r_state == StBeat1) && bus_ready) begin
            r_raw <= r_raw | (bus_rdata << w_hi_sh);
         end
      end
   end

endmodule

// File: tb/tb_m_ldst_unit.sv
// ---------------------------------------------------------------------------
// tb_m_ldst_unit
// Bench for m_ldst_unit with DATA_W=32. Two instances share the stimulus:
// index 0 has ALLOW_UNALIGNED=0, index 1 has ALLOW_UNALIGNED=1; only the
// selected one sees req_valid. Expected bus beats and responses come from a
// byte-level model of each access.
// ---------------------------------------------------------------------------
module tb_m_ldst_unit;

   localparam int DW = 32;
   localparam int NB = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          sel;
   logic          req_valid;
   logic          req_we;
   logic [31:0]   req_addr;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [DW-1:0] req_wdata;
   logic          bus_ready;
   logic [DW-1:0] bus_rdata;

   logic [1:0]          o_req_ready;
   logic [1:0]          o_bus_valid;
   logic [1:0]          o_bus_we;
   logic [1:0][31:0]    o_bus_addr;
   logic [1:0][NB-1:0]  o_bus_be;
   logic [1:0][DW-1:0]  o_bus_wdata;
   logic [1:0]          o_rsp_valid;
   logic [1:0][DW-1:0]  o_rsp_rdata;
   logic [1:0]          o_rsp_exc;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      m_ldst_unit #(
         .DATA_W          (DW),
         .ALLOW_UNALIGNED (g)
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .req_valid  (req_valid && (sel == g)),
         .req_ready  (o_req_ready[g]),
         .req_we     (req_we),
         .req_addr   (req_addr),
         .req_size   (req_size),
         .req_signed (req_signed),
         .req_wdata  (req_wdata),
         .bus_valid  (o_bus_valid[g]),
         .bus_ready  (bus_ready),
         .bus_we     (o_bus_we[g]),
         .bus_addr   (o_bus_addr[g]),
         .bus_be     (o_bus_be[g]),
         .bus_wdata  (o_bus_wdata[g]),
         .bus_rdata  (bus_rdata),
         .rsp_valid  (o_rsp_valid[g]),
         .rsp_rdata  (o_rsp_rdata[g]),
         .rsp_exc    (o_rsp_exc[g])
      );
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request into instance s and check every cycle until it retires.
   task automatic run_txn(input logic s, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic we, input logic [31:0] wd,
                          input logic [31:0] rd0, input logic [31:0] rd1,
                          input int st0, input int st1);
      int          n, off, nbeats, pos, st;
      logic        fault;
      logic [31:0] base;
      logic [3:0]  be [2];
      logic [31:0] wdb [2];
      logic [31:0] rdb [2];
      logic [7:0]  byt;
      longint      val;
      logic [31:0] exp_rd;

      // Reference model: plain byte arithmetic over two consecutive words.
      n      = 1 << size;
      off    = int'(addr % 32'd4);
      base   = addr - 32'(off);
      fault  = (size == 2'd3) || (!s && ((addr % 32'(n)) != 0));
      nbeats = (off + n > NB) ? 2 : 1;
      rdb[0] = rd0;
      rdb[1] = rd1;
      for (int b = 0; b < 2; b++) begin
         be[b]  = '0;
         wdb[b] = '0;
      end
      for (int k = 0; k < n; k++) begin
         pos = off + k;
         be[pos / NB][pos % NB] = 1'b1;
      end
      for (int l = 0; l < NB; l++) begin
         if (l >= off) begin
            byt = 8'(wd >> (8 * (l - off)));
            wdb[0] = wdb[0] | (32'(byt) << (8 * l));
         end
         if (l < off) begin
            byt = 8'(wd >> (8 * (NB - off + l)));
            wdb[1] = wdb[1] | (32'(byt) << (8 * l));
         end
      end
      val = 0;
      for (int k = 0; k < n; k++) begin
         pos = off + k;
         byt = 8'(rdb[pos / NB] >> (8 * (pos % NB)));
         val = val + (longint'(byt) << (8 * k));
      end
      if (sgn && n < NB && val >= (longint'(1) << (8 * n - 1))) begin
         val = val - (longint'(1) << (8 * n));
      end
      exp_rd = we ? 32'h0 : val[31:0];

      sel        = s;
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_size   = size;
      req_signed = sgn;
      req_wdata  = wd;
      check("req_ready_idle", 64'(o_req_ready[s]), 64'd1);
      tick();
      req_valid = 1'b0;

      if (fault) begin
         check("fault_rsp_valid", 64'(o_rsp_valid[s]), 64'd1);
         check("fault_rsp_exc", 64'(o_rsp_exc[s]), 64'd1);
         check("fault_rsp_rdata", 64'(o_rsp_rdata[s]), 64'd0);
         check("fault_bus_valid", 64'(o_bus_valid[s]), 64'd0);
         check("fault_req_ready", 64'(o_req_ready[s]), 64'd0);
         tick();
         check("fault_rsp_done", 64'(o_rsp_valid[s]), 64'd0);
         return;
      end

      for (int b = 0; b < nbeats; b++) begin
         st = (b == 0) ? st0 : st1;
         for (int c = 0; c <= st; c++) begin
            bus_ready = (c == st);
            bus_rdata = (c == st) ? rdb[b] : $urandom;
            check($sformatf("beat%0d_bus_valid", b), 64'(o_bus_valid[s]), 64'd1);
            check($sformatf("beat%0d_bus_addr", b), 64'(o_bus_addr[s]), 64'(base + 32'(4 * b)));
            check($sformatf("beat%0d_bus_be", b), 64'(o_bus_be[s]), 64'(be[b]));
            check($sformatf("beat%0d_bus_wdata", b), 64'(o_bus_wdata[s]), 64'(wdb[b]));
            check($sformatf("beat%0d_bus_we", b), 64'(o_bus_we[s]), 64'(we));
            check($sformatf("beat%0d_rsp_quiet", b), 64'(o_rsp_valid[s]), 64'd0);
            tick();
         end
      end
      bus_ready = 1'b0;
      check("rsp_valid", 64'(o_rsp_valid[s]), 64'd1);
      check("rsp_exc", 64'(o_rsp_exc[s]), 64'd0);
      check("rsp_rdata", 64'(o_rsp_rdata[s]), 64'(exp_rd));
      check("rsp_bus_valid", 64'(o_bus_valid[s]), 64'd0);
      check("rsp_req_ready", 64'(o_req_ready[s]), 64'd0);
      tick();
      check("rsp_done_valid", 64'(o_rsp_valid[s]), 64'd0);
      check("rsp_done_rdata", 64'(o_rsp_rdata[s]), 64'd0);
      check("rsp_done_ready", 64'(o_req_ready[s]), 64'd1);
   endtask

   task automatic check_idle(input int g, input string tag);
      check({tag, "_req_ready"}, 64'(o_req_ready[g]), 64'd1);
      check({tag, "_bus_valid"}, 64'(o_bus_valid[g]), 64'd0);
      check({tag, "_bus_be"}, 64'(o_bus_be[g]), 64'd0);
      check({tag, "_bus_we"}, 64'(o_bus_we[g]), 64'd0);
      check({tag, "_bus_addr"}, 64'(o_bus_addr[g]), 64'd0);
      check({tag, "_bus_wdata"}, 64'(o_bus_wdata[g]), 64'd0);
      check({tag, "_rsp_valid"}, 64'(o_rsp_valid[g]), 64'd0);
      check({tag, "_rsp_rdata"}, 64'(o_rsp_rdata[g]), 64'd0);
      check({tag, "_rsp_exc"}, 64'(o_rsp_exc[g]), 64'd0);
   endtask

   // Split load on the unaligned instance, reset while BEAT1 is on the bus.
   task automatic reset_mid_beat1();
      sel        = 1'b1;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 32'h0000_4002;
      req_size   = 2'd2;
      req_signed = 1'b0;
      req_wdata  = '0;
      tick();
      req_valid = 1'b0;
      bus_ready = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      check("rst_beat0_addr", 64'(o_bus_addr[1]), 64'h4000);
      tick();
      bus_ready = 1'b0;
      check("rst_beat1_valid", 64'(o_bus_valid[1]), 64'd1);
      check("rst_beat1_addr", 64'(o_bus_addr[1]), 64'h4004);
      // Reset with competing req_valid and bus_ready.
      reset     = 1'b1;
      req_valid = 1'b1;
      bus_ready = 1'b1;
      tick();
      check_idle(1, "rst_mid");
      reset     = 1'b0;
      req_valid = 1'b0;
      bus_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst_after_rsp_valid", 64'(o_rsp_valid[1]), 64'd0);
         check("rst_after_bus_valid", 64'(o_bus_valid[1]), 64'd0);
      end
   endtask

   initial begin
      logic        s, sgn, we;
      logic [31:0] addr, wd;
      logic [1:0]  size;

      sel        = 1'b0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_size   = '0;
      req_signed = 1'b0;
      req_wdata  = '0;
      bus_ready  = 1'b0;
      bus_rdata  = '0;
      tick();
      tick();
      check_idle(0, "reset0");
      check_idle(1, "reset1");
      reset = 1'b0;
      tick();

      // Directed cases.
      run_txn(1'b0, 32'h0000_1003, 2'd0, 1'b1, 1'b0, 32'h0, 32'h80FF_1234, 32'h0, 0, 0);
      run_txn(1'b0, 32'h0000_2002, 2'd1, 1'b0, 1'b0, 32'h0, 32'hABCD_0000, 32'h0, 0, 0);
      run_txn(1'b1, 32'h0000_3003, 2'd2, 1'b0, 1'b1, 32'h1122_3344, 32'h0, 32'h0, 0, 0);
      run_txn(1'b0, 32'h0000_3003, 2'd2, 1'b0, 1'b1, 32'h1122_3344, 32'h0, 32'h0, 0, 0);
      run_txn(1'b0, 32'h0000_5008, 2'd2, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 32'h0, 3, 0);
      run_txn(1'b1, 32'h0000_6003, 2'd1, 1'b1, 1'b0, 32'h0, 32'h9900_0000, 32'h0000_0081, 1, 2);
      run_txn(1'b1, 32'h0000_7000, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
      reset_mid_beat1();

      // Randomized accesses, half of them forced to natural alignment.
      for (int i = 0; i < 250; i++) begin
         s    = 1'($urandom_range(0, 1));
         addr = $urandom;
         size = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            addr = addr & ~((32'd1 << size) - 32'd1);
         end
         sgn = 1'($urandom_range(0, 1));
         we  = 1'($urandom_range(0, 1));
         wd  = $urandom;
         run_txn(s, addr, size, sgn, we, wd, $urandom, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) begin
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1);
   end

endmodule
